// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the MIPS MEM stage: accepts a read or
// write, stalls the pipeline for LATENCY busy cycles, then commits or returns data.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_read_i,
    input  logic        req_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int CW = $clog2(LATENCY) + 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [29:0]   DEPTH_L  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          both_q, both_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          req_s;
    logic [29:0]   idx_s;
    logic          err_s;
    logic          access_s;
    logic          mem_we_s;
    logic          stall_s;
    logic [31:0]   mem_rdata_s;

    logic [31:0]   mem [DEPTH_WORDS];

    // Next-state, counter, latch and completion logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        both_d      = both_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        req_s       = req_read_i | req_write_i;
        idx_s       = addr_q[31:2];
        // Both-requested is folded in as an error so the write never commits.
        err_s       = (addr_q[1:0] != 2'b00) || (idx_s >= DEPTH_L) || both_q;
        access_s    = (state_q == BUSY) && (cnt_q == {CW{1'b0}});
        mem_we_s    = access_s & wr_q & ~err_s;
        mem_rdata_s = mem[idx_s[AW-1:0]];
        stall_s     = ((state_q == IDLE) & req_s) | (state_q == BUSY);
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wr_d    = req_write_i;
                    both_d  = req_read_i & req_write_i;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (access_s) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = err_s;
                    if (!wr_q) begin
                        rdata_d = err_s ? 32'h0000_0000 : mem_rdata_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            rdata_q <= 32'h0000_0000;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem[idx_s[AW-1:0]] <= wdata_q;
        end
    end

    assign stall_o = stall_s;
    assign rdata_o = rdata_q;
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios plus a
// randomized sequence checked against an array-based memory model.
module tb_data_memory_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_read_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        error_o;

    int checks = 0;
    int failures = 0;
    int done_total = 0;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .stall_o(stall_o),
        .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (done_o === 1'b1) done_total++;

    // Drive one request from posedge+1 until its done pulse; returns at posedge+1
    // of the cycle after DONE with the request still applied.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, output int stalls,
                             output logic [31:0] rdv, output logic errv, output bit ok);
        req_read_i = rd; req_write_i = wr; addr_i = a; wdata_i = d;
        stalls = 0; ok = 1'b0; rdv = 32'h0; errv = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (stall_o === 1'b1) stalls++;
            if (done_o === 1'b1) begin
                ok = 1'b1; rdv = rdata_o; errv = error_o;
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic idle_req();
        req_read_i = 1'b0; req_write_i = 1'b0;
    endtask

    task automatic test_reset();
        #22 rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (stall_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0 || rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset: stall=%b done=%b err=%b rdata=%h, need 0 0 0 00000000",
                     stall_o, done_o, error_o, rdata_o);
        end
        repeat (2) @(posedge clk_i); #1;
        checks++;
        if (stall_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL idle: stall=%b done=%b, need 0 0", stall_o, done_o);
        end
    endtask

    task automatic test_write_read();
        int st; logic [31:0] rv; logic ev; bit ok;
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, rv, ev, ok);
        idle_req(); #1;
        checks++;
        if (!ok || st != LAT + 1 || ev !== 1'b0) begin
            failures++;
            $display("FAIL write_profile: done=%0d stalls=%0d err=%b, need 1 %0d 0", ok, st, ev, LAT + 1);
        end
        checks++;
        if (done_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL write_single_pulse: done=%b stall=%b after DONE, need 0 0", done_o, stall_o);
        end
        @(posedge clk_i); #1;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, st, rv, ev, ok);
        idle_req();
        checks++;
        if (!ok || st != LAT + 1 || ev !== 1'b0 || rv !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_0x10: done=%0d stalls=%0d err=%b rdata=%h, need 1 %0d 0 deadbeef",
                     ok, st, ev, rv, LAT + 1);
        end
        @(posedge clk_i); #1;
        checks++;
        if (rdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rdata_hold: got %h need deadbeef", rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        int st1, st2, d0; logic [31:0] rv1, rv2; logic ev1, ev2; bit ok1, ok2;
        d0 = done_total;
        do_access(1'b0, 1'b1, 32'h20, 32'h5, st1, rv1, ev1, ok1);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, st2, rv2, ev2, ok2);
        idle_req();
        repeat (3) @(posedge clk_i); #1;
        checks++;
        if (!ok1 || !ok2 || st1 != LAT + 1 || st2 != LAT + 1) begin
            failures++;
            $display("FAIL b2b_profile: done=%0d/%0d stalls=%0d/%0d, need 1/1 %0d/%0d",
                     ok1, ok2, st1, st2, LAT + 1, LAT + 1);
        end
        checks++;
        if (rv2 !== 32'h5 || ev2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_read: rdata=%h err=%b, need 00000005 0", rv2, ev2);
        end
        checks++;
        if (done_total - d0 != 2) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d done pulses, need 2", done_total - d0);
        end
    endtask

    task automatic test_errors();
        int st; logic [31:0] rv; logic ev; bit ok;
        do_access(1'b1, 1'b0, 32'h13, 32'h0, st, rv, ev, ok);
        checks++;
        if (!ok || st != LAT + 1 || ev !== 1'b1 || rv !== 32'h0) begin
            failures++;
            $display("FAIL misaligned_read: done=%0d stalls=%0d err=%b rdata=%h, need 1 %0d 1 00000000",
                     ok, st, ev, rv, LAT + 1);
        end
        do_access(1'b1, 1'b0, 32'h400, 32'h0, st, rv, ev, ok);
        checks++;
        if (!ok || ev !== 1'b1 || rv !== 32'h0) begin
            failures++;
            $display("FAIL range_read: done=%0d err=%b rdata=%h, need 1 1 00000000", ok, ev, rv);
        end
        do_access(1'b0, 1'b1, 32'h22, 32'h1, st, rv, ev, ok);
        checks++;
        if (!ok || ev !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_write: done=%0d err=%b, need 1 1", ok, ev);
        end
        do_access(1'b1, 1'b0, 32'h20, 32'h0, st, rv, ev, ok);
        idle_req();
        checks++;
        if (!ok || ev !== 1'b0 || rv !== 32'h5) begin
            failures++;
            $display("FAIL word_0x20_intact: err=%b rdata=%h, need 0 00000005", ev, rv);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_both();
        int st; logic [31:0] rv; logic ev; bit ok;
        do_access(1'b0, 1'b1, 32'h30, 32'h12345678, st, rv, ev, ok);
        do_access(1'b1, 1'b1, 32'h30, 32'h7, st, rv, ev, ok);
        checks++;
        if (!ok || ev !== 1'b1) begin
            failures++;
            $display("FAIL both_req: done=%0d err=%b, need 1 1", ok, ev);
        end
        do_access(1'b1, 1'b0, 32'h30, 32'h0, st, rv, ev, ok);
        idle_req();
        checks++;
        if (!ok || ev !== 1'b0 || rv !== 32'h12345678) begin
            failures++;
            $display("FAIL both_mem_intact: err=%b rdata=%h, need 0 12345678", ev, rv);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_abort();
        int st, d0; logic [31:0] rv; logic ev; bit ok;
        bit quiet;
        do_access(1'b0, 1'b1, 32'h40, 32'h11111111, st, rv, ev, ok);
        idle_req();
        @(posedge clk_i); #1;
        d0 = done_total;
        req_write_i = 1'b1; addr_i = 32'h40; wdata_i = 32'hCAFEF00D;
        repeat (2) @(posedge clk_i); #1;
        rst_i = 1'b1; idle_req(); #1;
        checks++;
        if (stall_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_immediate: stall=%b done=%b, need 0 0", stall_o, done_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            if (stall_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (done_total != d0 || !quiet) begin
            failures++;
            $display("FAIL abort_no_done: pulses=%0d quiet=%0d, need 0 1", done_total - d0, quiet);
        end
        do_access(1'b1, 1'b0, 32'h40, 32'h0, st, rv, ev, ok);
        idle_req();
        checks++;
        if (!ok || rv !== 32'h11111111) begin
            failures++;
            $display("FAIL abort_mem_intact: rdata=%h, need 11111111", rv);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_in_done();
        req_read_i = 1'b1; addr_i = 32'h10;
        repeat (LAT + 1) @(posedge clk_i); #1;
        checks++;
        if (done_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL done_cycle: done=%b rdata=%h, need 1 deadbeef", done_o, rdata_o);
        end
        rst_i = 1'b1; idle_req(); #1;
        checks++;
        if (done_o !== 1'b0 || error_o !== 1'b0 || rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_done: done=%b err=%b rdata=%h, need 0 0 00000000",
                     done_o, error_o, rdata_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_random();
        logic [31:0] mm [DEPTH];
        bit known [DEPTH];
        logic [31:0] exp_rd;
        bit exp_known;
        int st, sel, g, idx;
        logic [31:0] a, d, rv;
        logic rd, wr, ev, err;
        bit ok;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        exp_rd = 32'h0; exp_known = 1'b1;   // previous test left rdata cleared by reset
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 8);
            wr  = (sel <= 3) || (sel == 8);
            rd  = (sel >= 4);
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'h200 + ($urandom_range(0, 15) << 2);
            else if (sel == 7) a = 32'h200 + $urandom_range(1, 3);
            else if (sel == 8) a = 32'h400 + ($urandom_range(0, 63) << 2);
            else               a = 32'h8000_0000;
            d = $urandom;
            err = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH) || (rd && wr);
            idx = int'(a[9:2]);
            do_access(rd, wr, a, d, st, rv, ev, ok);
            if (wr) begin
                if (!err) begin mm[idx] = d; known[idx] = 1'b1; end
            end else if (err) begin
                exp_rd = 32'h0; exp_known = 1'b1;
            end else if (known[idx]) begin
                exp_rd = mm[idx]; exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
            checks++;
            if (!ok || st != LAT + 1 || ev !== err) begin
                failures++;
                $display("FAIL rand_ctrl[%0d] a=%h rd=%b wr=%b: done=%0d stalls=%0d err=%b, need 1 %0d %b",
                         n, a, rd, wr, ok, st, ev, LAT + 1, err);
            end
            if (exp_known) begin
                checks++;
                if (rv !== exp_rd) begin
                    failures++;
                    $display("FAIL rand_data[%0d] a=%h: rdata=%h, need %h", n, a, rv, exp_rd);
                end
            end
            g = $urandom_range(0, 2);
            if (g > 0) begin
                idle_req();
                repeat (g) @(posedge clk_i);
                #1;
            end
        end
        idle_req();
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_both();
        test_reset_abort();
        test_reset_in_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder serving the MEM stage of the pipelined MIPS CPU. The MEM stage issues a read or write per instruction; this block accepts the request, holds the pipeline with `stall_o` for a fixed access latency, then commits the write or returns the read word. It replaces the zero-latency data memory and models a slow memory port for stall and hazard verification.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words stored; word index = `addr_i[31:2]`.
- `LATENCY`, 3: BUSY cycles per access, must be ≥ 1.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_read_i` in 1: MEM-stage MemRead; held stable by the CPU while `stall_o`=1.
- `req_write_i` in 1: MEM-stage MemWrite; held stable by the CPU while `stall_o`=1.
- `addr_i` in 32: byte address (ALU result).
- `wdata_i` in 32: store data.
- `rdata_o` out 32: read data, registered; valid when `done_o`=1.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- `done_o` out 1: one-cycle completion pulse.
- `error_o` out 1: completion carries an error; valid only with `done_o`.

## Operation
- FSM states: IDLE, BUSY, DONE. Down-counter `cnt`, width clog2(LATENCY)+1.
- IDLE: if `req_read_i | req_write_i`, latch addr, wdata, and op. Write wins if both are asserted, and the error flag is set. Load `cnt` = LATENCY-1 and go to BUSY. Otherwise stay in IDLE.
- BUSY: if `cnt` ≠ 0, decrement. If `cnt` = 0, perform the access at this edge and go to DONE.
  - Write: `mem[idx]` ← latched wdata.
  - Read: `rdata_o` ← `mem[idx]`.
- Error condition: latched `addr[1:0]` ≠ 0, or `idx` ≥ DEPTH_WORDS, or both read and write requested.
  - On error, no memory write occurs and `rdata_o` ← 0.
  - The error flag is registered and presented as `error_o` in DONE.
- DONE: `done_o`=1, `error_o` as latched, `stall_o`=0. Go to IDLE unconditionally.
- `stall_o` = (IDLE & (`req_read_i` | `req_write_i`)) | BUSY. Combinational in IDLE so the pipeline freezes in the request cycle.
- `rdata_o` holds its value between reads. Writes and errored writes leave it unchanged; errored reads force 0.
- Request inputs are ignored in BUSY and DONE. Only the IDLE-cycle latch is used.
- Memory array is not reset; contents are X until written.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata_o` 0, `done_o` 0, `error_o` 0.
- Reset with no request: `stall_o` 0.
- Access timeline, request first seen at cycle t:
  - `stall_o`=1 for cycles t .. t+LATENCY, which is LATENCY+1 cycles.
  - `done_o`=1 at cycle t+LATENCY+1, with `stall_o`=0.
  - The pipeline advances at the end of the DONE cycle.
- Back-to-back: a new request present in the cycle after DONE is accepted in IDLE. There is no idle gap beyond DONE.
- A request that is still asserted during DONE is not re-accepted.
- LATENCY=1: one BUSY cycle; the access happens at the first BUSY edge.
- Reset asserted in BUSY: immediate return to IDLE.
  - A pending write is aborted and memory is untouched.
  - `done_o` is never pulsed for the aborted access.
- Reset asserted in DONE: `done_o`, `error_o`, and `rdata_o` clear asynchronously.
- Read-after-write to the same address on consecutive accesses returns the new data; the write commits before DONE.

## Test plan
- Reset, then idle with no requests: `stall_o`=0, `done_o`=0, `rdata_o`=0.
- Write 0xDEADBEEF to 0x10 with LATENCY=3: `stall_o` high for 4 cycles, `done_o` pulses once with `error_o`=0. Then read 0x10: same stall profile, `rdata_o`=0xDEADBEEF at `done_o`.
- Back-to-back write 0x00000005 to 0x20, then read 0x20, with requests held until DONE:
  - Second request accepted in the cycle after DONE.
  - Read returns 0x00000005.
  - Exactly 2 `done_o` pulses.
- Misaligned read 0x13, and read 0x400 with DEPTH_WORDS=256:
  - `error_o`=1 with `done_o`, `rdata_o`=0.
  - A misaligned write 0x22 of 0x1 leaves word 0x20 unchanged (read back 0x00000005).
- Both `req_read_i` and `req_write_i` high at 0x30 with data 0x7: `error_o`=1, memory at 0x30 unchanged on readback.
- Write 0xCAFEF00D to 0x40 with `rst_i` pulsed during the 2nd BUSY cycle:
  - FSM returns to IDLE, `stall_o` drops, no `done_o`.
  - A later read of 0x40 returns the prior contents, not 0xCAFEF00D.
